// File: rtl/cfu_issue.sv
// Execute-stage adapter that issues one instruction at a time to a custom function unit (CFU) and holds its result for writeback.
// Optional watchdog: define CFU_TIMEOUT_EN to force completion after TIMEOUT_CYCLES stalled EXEC cycles.
module cfu_issue #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [31:0]      src1_i,
    input  logic [31:0]      src2_i,
    input  logic             flush_i,
    output logic             cfu_en_o,
    output logic [2:0]       cfu_funct3_o,
    output logic [6:0]       cfu_funct7_o,
    output logic [31:0]      cfu_src1_o,
    output logic [31:0]      cfu_src2_o,
    input  logic             cfu_stall_i,
    input  logic [31:0]      cfu_rslt_i,
    output logic             rslt_valid_o,
    output logic [31:0]      rslt_o,
    input  logic             rslt_ready_i,
    output logic [CNT_W-1:0] busy_cycles_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        funct3_q;
    logic [6:0]        funct7_q;
    logic [31:0]       src1_q, src2_q;
    logic [31:0]       rslt_q;
    logic [CNT_W-1:0]  busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              discard_q;

    logic              issue_ready;
    logic              issue_fire;
    logic [CNT_W-1:0]  cnt_inc;
    logic              done_normal;
    logic              timeout_hit;
    logic              op_done;
    logic              discard_now;

    // busy_cycles_o must be able to report a watchdog completion.
    if ((TIMEOUT_CYCLES < 1) || (longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W))) begin : g_bad_timeout
        $error("cfu_issue: TIMEOUT_CYCLES does not fit in CNT_W bits");
    end

    assign issue_fire  = issue_valid_i & issue_ready;
    assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign done_normal = (state_q == S_EXEC) & ~cfu_stall_i;
    // A flush landing on the completing cycle still drops that result.
    assign discard_now = discard_q | flush_i;
    assign op_done     = done_normal | timeout_hit;

`ifdef CFU_TIMEOUT_EN
    localparam logic [CNT_W:0]   TO_LIM  = (CNT_W+1)'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_BUSY = CNT_W'(TIMEOUT_CYCLES);

    logic err_q;

    assign timeout_hit = (state_q == S_EXEC) & cfu_stall_i &
                         (({1'b0, cnt_q} + 1'b1) >= TO_LIM);
    assign err_o       = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (issue_fire) begin
            err_q <= 1'b0;
        end else if (timeout_hit && !discard_now) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: state_d gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue_fire) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_done) state_d = discard_now ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (rslt_ready_i) begin
                    state_d = issue_valid_i ? S_EXEC : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        issue_ready  = 1'b0;
        cfu_en_o     = 1'b0;
        rslt_valid_o = 1'b0;
        case (state_q)
            S_IDLE: issue_ready = ~flush_i;
            S_EXEC: cfu_en_o = 1'b1;
            S_HOLD: begin
                rslt_valid_o = 1'b1;
                issue_ready  = rslt_ready_i & ~flush_i;
            end
            default: ;
        endcase
    end

    // Operand, result and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            funct3_q  <= '0;
            funct7_q  <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            rslt_q    <= '0;
            busy_q    <= '0;
            cnt_q     <= '0;
            discard_q <= 1'b0;
        end else begin
            if (issue_fire) begin
                funct3_q  <= funct3_i;
                funct7_q  <= funct7_i;
                src1_q    <= src1_i;
                src2_q    <= src2_i;
                cnt_q     <= '0;
                discard_q <= 1'b0;
            end
            if (state_q == S_EXEC) begin
                cnt_q <= cnt_inc;
                if (flush_i) discard_q <= 1'b1;
                if (op_done) begin
                    discard_q <= 1'b0;
                    if (!discard_now) begin
`ifdef CFU_TIMEOUT_EN
                        if (timeout_hit) begin
                            rslt_q <= '0;
                            busy_q <= TO_BUSY;
                        end else begin
                            rslt_q <= cfu_rslt_i;
                            busy_q <= cnt_inc;
                        end
`else
                        rslt_q <= cfu_rslt_i;
                        busy_q <= cnt_inc;
`endif
                    end
                end
            end
        end
    end

    assign issue_ready_o = issue_ready;
    assign cfu_funct3_o  = funct3_q;
    assign cfu_funct7_o  = funct7_q;
    assign cfu_src1_o    = src1_q;
    assign cfu_src2_o    = src2_q;
    assign rslt_o        = rslt_q;
    assign busy_cycles_o = busy_q;

endmodule

// File: tb/tb_cfu_issue.sv
// Self-checking bench for cfu_issue: directed scenarios then randomized ops against a transaction-level timing model.
// Build with CFU_TIMEOUT_EN defined to exercise the watchdog (TIMEOUT_CYCLES=8 here).
module tb_cfu_issue;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] s1;
        logic [31:0] s2;
    } op_t;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             issue_valid_i;
    logic             issue_ready_o;
    logic [2:0]       funct3_i;
    logic [6:0]       funct7_i;
    logic [31:0]      src1_i, src2_i;
    logic             flush_i;
    logic             cfu_en_o;
    logic [2:0]       cfu_funct3_o;
    logic [6:0]       cfu_funct7_o;
    logic [31:0]      cfu_src1_o, cfu_src2_o;
    logic             cfu_stall_i;
    logic [31:0]      cfu_rslt_i;
    logic             rslt_valid_o;
    logic [31:0]      rslt_o;
    logic             rslt_ready_i;
    logic [CNT_W-1:0] busy_cycles_o;
    logic             err_o;

    int n_checks = 0;
    int n_fail   = 0;

    cfu_issue #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .src1_i(src1_i), .src2_i(src2_i),
        .flush_i(flush_i),
        .cfu_en_o(cfu_en_o), .cfu_funct3_o(cfu_funct3_o), .cfu_funct7_o(cfu_funct7_o),
        .cfu_src1_o(cfu_src1_o), .cfu_src2_o(cfu_src2_o),
        .cfu_stall_i(cfu_stall_i), .cfu_rslt_i(cfu_rslt_i),
        .rslt_valid_o(rslt_valid_o), .rslt_o(rslt_o), .rslt_ready_i(rslt_ready_i),
        .busy_cycles_o(busy_cycles_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // CFU model: OR of the sources, tagged with funct7/funct3 so swapped fields show up.
    function automatic logic [31:0] cfu_fn(input op_t op);
        return (op.s1 | op.s2) ^ {op.f7, op.f3, 22'h0};
    endfunction

    assign cfu_rslt_i = cfu_en_o ?
        cfu_fn('{f3: cfu_funct3_o, f7: cfu_funct7_o, s1: cfu_src1_o, s2: cfu_src2_o}) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic op_t rand_op();
        op_t op;
        op.f3 = 3'($urandom_range(0, 7));
        op.f7 = 7'($urandom_range(0, 127));
        op.s1 = $urandom;
        op.s2 = $urandom;
        return op;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(issue_ready_o), 1);
        check({tag, "_en"}, 32'(cfu_en_o), 0);
        check({tag, "_f3"}, 32'(cfu_funct3_o), 0);
        check({tag, "_f7"}, 32'(cfu_funct7_o), 0);
        check({tag, "_s1"}, cfu_src1_o, 0);
        check({tag, "_s2"}, cfu_src2_o, 0);
        check({tag, "_valid"}, 32'(rslt_valid_o), 0);
        check({tag, "_rslt"}, rslt_o, 0);
        check({tag, "_busy"}, 32'(busy_cycles_o), 0);
        check({tag, "_err"}, 32'(err_o), 0);
    endtask

    // Present op in a cycle where the block must be ready; accepted on the next edge.
    task automatic issue(input op_t op);
        issue_valid_i = 1'b1;
        funct3_i = op.f3; funct7_i = op.f7; src1_i = op.s1; src2_i = op.s2;
        #1;
        check("issue_ready", 32'(issue_ready_o), 1);
        cyc();
        issue_valid_i = 1'b0;
        rslt_ready_i  = 1'b0;
        src1_i = $urandom; src2_i = $urandom;
    endtask

    // EXEC lasts stalls+1 cycles; operands must stay put and no new issue may be accepted.
    task automatic exec_op(input op_t op, input int stalls, input int flush_at);
        for (int k = 0; k <= stalls; k++) begin
            cfu_stall_i   = (k < stalls);
            flush_i       = (k == flush_at);
            issue_valid_i = 1'($urandom_range(0, 1));
            src1_i        = $urandom;
            #1;
            check("exec_en", 32'(cfu_en_o), 1);
            check("exec_f3", 32'(cfu_funct3_o), 32'(op.f3));
            check("exec_f7", 32'(cfu_funct7_o), 32'(op.f7));
            check("exec_s1", cfu_src1_o, op.s1);
            check("exec_s2", cfu_src2_o, op.s2);
            check("exec_valid", 32'(rslt_valid_o), 0);
            check("exec_ready", 32'(issue_ready_o), 0);
            cyc();
        end
        cfu_stall_i   = 1'b0;
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
    endtask

    // HOLD with writeback back-pressuring for `waits` cycles.
    task automatic hold_wait(input logic [31:0] rslt, input int busy, input int waits);
        rslt_ready_i = 1'b0;
        for (int w = 0; w < waits; w++) begin
            issue_valid_i = 1'($urandom_range(0, 1));
            src1_i        = $urandom;
            #1;
            check("hold_valid", 32'(rslt_valid_o), 1);
            check("hold_rslt", rslt_o, rslt);
            check("hold_busy", 32'(busy_cycles_o), 32'(busy));
            check("hold_err", 32'(err_o), 0);
            check("hold_en", 32'(cfu_en_o), 0);
            check("hold_ready", 32'(issue_ready_o), 0);
            cyc();
        end
        issue_valid_i = 1'b0;
    endtask

    // Final HOLD cycle: writeback takes the result (the caller advances the clock).
    task automatic hold_last(input logic [31:0] rslt, input int busy, input logic exp_ready);
        rslt_ready_i  = 1'b1;
        issue_valid_i = 1'b0;
        #1;
        check("last_valid", 32'(rslt_valid_o), 1);
        check("last_rslt", rslt_o, rslt);
        check("last_busy", 32'(busy_cycles_o), 32'(busy));
        check("last_ready", 32'(issue_ready_o), 32'(exp_ready));
    endtask

    task automatic go_idle();
        cyc();
        rslt_ready_i = 1'b0;
        #1;
        check("idle_valid", 32'(rslt_valid_o), 0);
        check("idle_en", 32'(cfu_en_o), 0);
        check("idle_ready", 32'(issue_ready_o), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    initial begin
        op_t op, nxt;
        int  stalls, waits, fl;
        bit  accepted;

        rst_i = 1'b1; issue_valid_i = 1'b0; funct3_i = '0; funct7_i = '0;
        src1_i = '0; src2_i = '0; flush_i = 1'b0; cfu_stall_i = 1'b0; rslt_ready_i = 1'b0;
        cyc();
        cyc();
        check_reset_vals("rst");
        rst_i = 1'b0;

        // Zero-stall op: enable at T+1, result at T+2 with busy=1.
        op = '{f3: 3'd0, f7: 7'd0, s1: 32'h0F0F_0000, s2: 32'h0000_00F0};
        issue(op);
        exec_op(op, 0, -1);
        hold_wait(32'h0F0F_00F0, 1, 0);
        hold_last(32'h0F0F_00F0, 1, 1'b1);
        go_idle();

        // Three stall cycles: four EXEC cycles, busy=4.
        op = rand_op();
        issue(op);
        exec_op(op, 3, -1);
        hold_wait(cfu_fn(op), 4, 0);
        hold_last(cfu_fn(op), 4, 1'b1);
        go_idle();

        // Back-pressure for 4 cycles, then back-to-back issue of 1|2.
        op = rand_op();
        issue(op);
        exec_op(op, 1, -1);
        hold_wait(cfu_fn(op), 2, 4);
        hold_last(cfu_fn(op), 2, 1'b1);
        nxt = '{f3: 3'd0, f7: 7'd0, s1: 32'd1, s2: 32'd2};
        issue(nxt);
        exec_op(nxt, 0, -1);
        hold_wait(32'h3, 1, 1);
        hold_last(32'h3, 1, 1'b1);
        go_idle();

        // Flush in IDLE blocks the issue.
        issue_valid_i = 1'b1; flush_i = 1'b1; src1_i = 32'h1234_5678;
        #1;
        check("idle_flush_ready", 32'(issue_ready_o), 0);
        cyc();
        issue_valid_i = 1'b0; flush_i = 1'b0;
        #1;
        check("idle_flush_en", 32'(cfu_en_o), 0);
        check("idle_flush_ready2", 32'(issue_ready_o), 1);

        // Flush in the 2nd of 3 stall cycles: CFU runs to completion, result dropped.
        op = rand_op();
        issue(op);
        exec_op(op, 3, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("xflush_valid", 32'(rslt_valid_o), 0);
            check("xflush_en", 32'(cfu_en_o), 0);
            check("xflush_ready", 32'(issue_ready_o), 1);
            cyc();
        end

        // Flush in HOLD: result withdrawn next cycle, concurrent issue ignored.
        op = rand_op();
        issue(op);
        exec_op(op, 0, -1);
        hold_wait(cfu_fn(op), 1, 1);
        flush_i = 1'b1;
        hold_last(cfu_fn(op), 1, 1'b0);
        issue_valid_i = 1'b1;
        cyc();
        flush_i = 1'b0; issue_valid_i = 1'b0; rslt_ready_i = 1'b0;
        #1;
        check("hflush_valid", 32'(rslt_valid_o), 0);
        check("hflush_en", 32'(cfu_en_o), 0);
        check("hflush_ready", 32'(issue_ready_o), 1);

        // Reset during a stall: everything back to reset values.
        op = rand_op();
        issue(op);
        cfu_stall_i = 1'b1;
        #1;
        check("rstx_en_before", 32'(cfu_en_o), 1);
        cyc();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0; cfu_stall_i = 1'b0;
        check_reset_vals("rstx");
        cyc();
        #1;
        check("rstx_stay_idle", 32'(rslt_valid_o), 0);

`ifdef CFU_TIMEOUT_EN
        // CFU stalls forever: watchdog completes after 8 EXEC cycles.
        op = rand_op();
        issue(op);
        cfu_stall_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("to_en", 32'(cfu_en_o), 1);
            check("to_valid_lo", 32'(rslt_valid_o), 0);
            cyc();
        end
        #1;
        check("to_valid", 32'(rslt_valid_o), 1);
        check("to_rslt", rslt_o, 0);
        check("to_err", 32'(err_o), 1);
        check("to_busy", 32'(busy_cycles_o), 8);
        check("to_en_off", 32'(cfu_en_o), 0);
        cfu_stall_i = 1'b0;
        hold_last(32'h0, 8, 1'b1);
        go_idle();
        check("to_err_idle", 32'(err_o), 1);
        op = rand_op();
        issue(op);
        #1;
        check("to_err_clr", 32'(err_o), 0);
        exec_op(op, 0, -1);
        hold_wait(cfu_fn(op), 1, 1);
        hold_last(cfu_fn(op), 1, 1'b1);
        go_idle();
`else
        // Without the watchdog a long stall simply waits.
        op = rand_op();
        issue(op);
        exec_op(op, 12, -1);
        hold_wait(cfu_fn(op), 13, 1);
        hold_last(cfu_fn(op), 13, 1'b1);
        go_idle();
`endif

        // Randomized ops: stalls, back-pressure, back-to-back issue and EXEC flushes.
        op = rand_op();
        accepted = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!accepted) issue(op);
            stalls = $urandom_range(0, 4);
            waits  = $urandom_range(0, 3);
            fl     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, stalls)) : -1;
            exec_op(op, stalls, fl);
            nxt = rand_op();
            if (fl >= 0) begin
                #1;
                check("rnd_flush_valid", 32'(rslt_valid_o), 0);
                check("rnd_flush_ready", 32'(issue_ready_o), 1);
                accepted = 1'b0;
            end else begin
                hold_wait(cfu_fn(op), stalls + 1, waits);
                hold_last(cfu_fn(op), stalls + 1, 1'b1);
                if ($urandom_range(0, 1) == 1) begin
                    issue(nxt);
                    accepted = 1'b1;
                end else begin
                    go_idle();
                    accepted = 1'b0;
                end
            end
            op = nxt;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cfu_issue.md
Name: cfu_issue

Overview:
- Execute-stage adapter between the CPU pipeline and the CFU.
- Accepts a CFU instruction with a valid/ready handshake and registers its funct3/funct7/src1/src2.
- Drives the CFU enable with those operands held stable for as long as the CFU asserts stall.
- Captures the CFU result and holds it on a valid/ready result port until writeback takes it. Handles pipeline flush.

Parameters:
- CNT_W, 16: width of the execute-cycle counter.
- TIMEOUT_CYCLES, 1024: watchdog limit in EXEC cycles; used only when CFU_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- issue_valid_i  in  1  pipeline presents a CFU instruction.
- issue_ready_o  out  1  block can accept an instruction this cycle.
- funct3_i  in  3  instruction funct3.
- funct7_i  in  7  instruction funct7.
- src1_i  in  32  rs1 value.
- src2_i  in  32  rs2 value.
- flush_i  in  1  pipeline flush (branch mispredict or trap).
- cfu_en_o  out  1  enable to the CFU.
- cfu_funct3_o  out  3  latched funct3.
- cfu_funct7_o  out  7  latched funct7.
- cfu_src1_o  out  32  latched src1.
- cfu_src2_o  out  32  latched src2.
- cfu_stall_i  in  1  CFU not finished this cycle.
- cfu_rslt_i  in  32  CFU result; valid when cfu_en_o=1 and cfu_stall_i=0.
- rslt_valid_o  out  1  result available.
- rslt_o  out  32  registered result.
- rslt_ready_i  in  1  writeback accepts the result.
- busy_cycles_o  out  CNT_W  EXEC cycles of the last completed op.
- err_o  out  1  result produced by the watchdog (see Optional Feature).

Behaviour:
- Reset values: state=IDLE; issue_ready_o=1 (combinational from IDLE). All of the following are 0: cfu_en_o, cfu_funct3_o, cfu_funct7_o, cfu_src1_o, cfu_src2_o, rslt_valid_o, rslt_o, busy_cycles_o, err_o, discard flag, counter.
- States:
  - IDLE: issue_ready_o=1. If issue_valid_i=1 and flush_i=0: latch the operands, clear the counter, go to EXEC.
  - EXEC: cfu_en_o=1 and operand outputs constant; counter increments each cycle, saturating at all-ones.
    - A cycle with cfu_stall_i=0 completes the op.
    - On completion, if discard=0: rslt_o<=cfu_rslt_i, busy_cycles_o<=counter+1, rslt_valid_o<=1, go to HOLD.
    - On completion, if discard=1: go to IDLE with no result and clear discard.
    - cfu_en_o drops in the cycle after completion.
  - HOLD: rslt_valid_o=1. rslt_o, busy_cycles_o and err_o are stable until rslt_ready_i=1.
    - issue_ready_o=rslt_ready_i, so ops can issue back-to-back.
    - Handshake with issue_valid_i=1: latch the new operands and go directly to EXEC.
    - Handshake without issue_valid_i: go to IDLE.
- Latency: issue accepted at edge T → cfu_en_o=1 in cycle T+1. If the CFU does not stall, rslt_valid_o=1 in cycle T+2. Each stall cycle adds one cycle.
- Flush:
  - In IDLE: flush_i has priority; issue_valid_i is ignored and issue_ready_o is forced to 0.
  - In EXEC: the CFU cannot be aborted. Set discard and keep cfu_en_o and operands until completion, then go to IDLE. issue_ready_o=0 throughout.
  - In HOLD: rslt_valid_o<=0 next cycle and go to IDLE. The handshake in that cycle is ignored and no new issue is accepted.
- While cfu_en_o=0, the operand outputs keep their last values; the CFU gates its result on enable.
- Reset mid-operation: return to reset values on the next edge; any in-flight result is lost.
- Counter saturation does not affect completion.

Optional Feature:
- Macro: CFU_TIMEOUT_EN.
- Defined:
  - If EXEC reaches TIMEOUT_CYCLES cycles with cfu_stall_i still 1, force completion.
  - Forced completion sets rslt_o<=32'h0, err_o<=1, busy_cycles_o<=TIMEOUT_CYCLES, cfu_en_o<=0.
  - Next state is HOLD, or IDLE if discard=1.
  - err_o clears on the next accepted issue.
- Undefined: no watchdog; EXEC waits indefinitely; err_o tied to 0.

Test Plan:
- Zero-stall op: issue src1=0x0F0F0000, src2=0x000000F0 at T; CFU model returns OR → cfu_en_o=1 at T+1; rslt_valid_o=1, rslt_o=0x0F0F00F0, busy_cycles_o=1 at T+2.
- Stall: CFU stalls 3 cycles → operand outputs constant for 4 EXEC cycles; rslt_valid_o at T+5; busy_cycles_o=4.
- Backpressure and back-to-back: rslt_ready_i=0 for 4 cycles → rslt_o held. Then rslt_ready_i=1 with a second issue (src1=1, src2=2) → cfu_en_o=1 the next cycle with no IDLE gap; result 0x3.
- Flush in EXEC: flush_i pulsed in the 2nd of 3 stall cycles → cfu_en_o held until stall drops, then IDLE; rslt_valid_o never asserted. Flush in HOLD → rslt_valid_o=0 next cycle.
- Reset mid-EXEC: rst_i=1 for 1 cycle during a stall → cfu_en_o=0 and issue_ready_o=1 the next cycle; all outputs at reset values.
- CFU_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, CFU stalls forever → after 8 EXEC cycles rslt_valid_o=1, rslt_o=0, err_o=1, busy_cycles_o=8.
